// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: baud selection, divider counts for the 1.8432 MHz
// system clock, and the receiver state encoding.
// The receiver's optional even-parity support is enabled with UART_RX_PARITY_EN.
package uart_rx_pkg;

  // Baud select; encodings above uart_115200 are out of range.
  typedef enum logic [2:0] {
    uart_9600   = 3'd0,
    uart_19200  = 3'd1,
    uart_38400  = 3'd2,
    uart_57600  = 3'd3,
    uart_115200 = 3'd4
  } uart_freq;

  localparam int UART_CNT_SIZE = 8;

  // Clock cycles per bit at 1.8432 MHz.
  localparam logic [UART_CNT_SIZE-1:0] UART_9600_CNT   = 8'd192;
  localparam logic [UART_CNT_SIZE-1:0] UART_19200_CNT  = 8'd96;
  localparam logic [UART_CNT_SIZE-1:0] UART_38400_CNT  = 8'd48;
  localparam logic [UART_CNT_SIZE-1:0] UART_57600_CNT  = 8'd32;
  localparam logic [UART_CNT_SIZE-1:0] UART_115200_CNT = 8'd16;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state;

  // Bit period for a baud select; zero marks an unsupported selection.
  function automatic logic [UART_CNT_SIZE-1:0] freq_to_cnt(input uart_freq f);
    logic [UART_CNT_SIZE-1:0] cnt;
    case (f)
      uart_9600:   cnt = UART_9600_CNT;
      uart_19200:  cnt = UART_19200_CNT;
      uart_38400:  cnt = UART_38400_CNT;
      uart_57600:  cnt = UART_57600_CNT;
      uart_115200: cnt = UART_115200_CNT;
      default:     cnt = '0;
    endcase
    return cnt;
  endfunction

  function automatic logic freq_valid(input uart_freq f);
    return freq_to_cnt(f) != '0;
  endfunction

endpackage

// File: rtl/uart_rx_clk_div.sv
// Bit-tick generator: a down-counter that pulses o_clk for one cycle at
// terminal count and reloads to i_cnt-1, giving one tick every i_cnt cycles.
// With RESET_TO_HALF the reset value is i_cnt/2, so the first tick after
// release lands half a bit period later (mid bit when released on an edge).
module uart_clk_div
  import uart_rx_pkg::*;
#(
  parameter int CNT_SIZE      = UART_CNT_SIZE,
  parameter bit RESET_TO_HALF = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [CNT_SIZE-1:0] i_cnt,
  output logic                o_clk
);

  logic [CNT_SIZE-1:0] cnt_q;
  logic [CNT_SIZE-1:0] cnt_d;

  // Next count: preset while held in reset, reload at terminal count.
  always_comb begin
    if (i_rst) begin
      cnt_d = RESET_TO_HALF ? (i_cnt >> 1) : (i_cnt - CNT_SIZE'(1));
    end else if (cnt_q == '0) begin
      cnt_d = i_cnt - CNT_SIZE'(1);
    end else begin
      cnt_d = cnt_q - CNT_SIZE'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    cnt_q <= cnt_d;
  end

  assign o_clk = ~i_rst & (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data and the
// o_parity_err output.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line; baud latched
// START  | waiting for mid start bit to confirm (high again = glitch)
// DATA   | shifting in data bits at each mid-bit tick
// PARITY | sampling the even-parity bit (parity builds only)
// STOP   | sampling the stop bit; publish byte or flag framing error
module uart_rx
  import uart_rx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  uart_freq   i_freq,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(UART_DATA_BITS - 1);

  // Synchronizer and edge detector.
  logic       sync1_q, sync1_d;
  logic       rx_s_q, rx_s_d;
  logic       rx_prev_q, rx_prev_d;
  logic [1:0] warm_q, warm_d;
  logic       fall_edge;

  // Frame state.
  uart_rx_state                state_q, state_d;
  uart_freq                    freq_q, freq_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]                  data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                        perr_pend_q, perr_pend_d;
  logic                        perr_q, perr_d;
`endif

  logic                     tick;
  logic                     div_rst;
  logic [UART_CNT_SIZE-1:0] div_cnt;

  // Synchronizer next values. The sync flops reset high, which is not a real
  // line sample; warm_q tracks when the pipeline holds genuine samples so a
  // line that is already low when reset releases is not seen as a new edge.
  always_comb begin
    sync1_d   = i_rx;
    rx_s_d    = sync1_q;
    warm_d    = {warm_q[0], 1'b1};
    rx_prev_d = warm_q[1] ? rx_s_q : 1'b0;
  end

  // Synchronizer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      warm_q    <= 2'b00;
      rx_prev_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      warm_q    <= warm_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  assign fall_edge = warm_q[1] & rx_prev_q & ~rx_s_q;

  // While idle the divider tracks the live baud select so its preset matches
  // the rate latched on the same edge that enters START.
  assign div_rst = i_rst | (state_q == IDLE);
  assign div_cnt = (state_q == IDLE) ? freq_to_cnt(i_freq) : freq_to_cnt(freq_q);

  uart_clk_div #(
    .CNT_SIZE      (UART_CNT_SIZE),
    .RESET_TO_HALF (1'b1)
  ) u_clk_div (
    .i_clk (i_clk),
    .i_rst (div_rst),
    .i_cnt (div_cnt),
    .o_clk (tick)
  );

  // Next-state and output logic for the frame FSM.
  always_comb begin
    state_d   = state_q;
    freq_d    = freq_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_pend_d = perr_pend_q;
    perr_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        freq_d    = i_freq;
        bit_cnt_d = '0;
        if (fall_edge && freq_valid(i_freq)) begin
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          perr_pend_d = (^shift_q) ^ rx_s_q;
          state_d     = STOP;
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = perr_pend_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      freq_q    <= uart_115200;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have a clock `i_clk`  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-002 The block SHALL have a reset `i_rst`  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have `i_freq`  input  uart_freq  baud select (uart_9600..uart_115200); sampled only while the block is IDLE.
REQ-004 The block SHALL have `i_rx`  input  1  asynchronous serial line, idle high.
REQ-005 The block SHALL have `o_data`  output  8  last received byte; held until the next valid byte.
REQ-006 The block SHALL have `o_valid`  output  1  one-cycle pulse, asserted when `o_data` updates.
REQ-007 The block SHALL have `o_frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have `o_busy`  output  1  high in every state other than IDLE.

Function
REQ-009 `i_rx` SHALL pass through a 2-FF synchronizer; all decisions SHALL use the synchronized value `rx_s`.
REQ-010 The format SHALL be 1 start bit, 8 data bits LSB first, 1 stop bit.
  - Optional parity per REQ-024.
REQ-011 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE SHALL move to START on a falling edge of `rx_s` (previous 1, current 0); a line that is low without an edge SHALL NOT start a frame.
REQ-013 The baud divider SHALL be held in reset while in IDLE and SHALL be released on entry to START.
  - Divider reset value is half of the selected count, so the first tick lands mid start bit.
  - Each later tick lands mid bit.
REQ-014 On a tick in START: `rx_s`=0 -> DATA with bit counter 0; `rx_s`=1 -> IDLE (glitch rejected); no output pulse in either case.
REQ-015 On each tick in DATA, the block SHALL shift `rx_s` into bit [7] of the shift register (right shift).
  - After the 8th tick: -> PARITY if enabled, else -> STOP.
REQ-016 On a tick in STOP: `rx_s`=1 -> `o_data`<=shift register and `o_valid`=1 for exactly one cycle; `rx_s`=0 -> `o_frame_err`=1 for one cycle and `o_data` unchanged.
  - Both outcomes return to IDLE.
REQ-017 After a framing error with the line held low (break), the block SHALL remain in IDLE until `rx_s` returns high and then falls.
REQ-018 Latency SHALL be `o_valid` asserted 1 cycle after the stop-bit tick (registered output).
REQ-019 Changes on `i_freq` while `o_busy`=1 SHALL be ignored; the frame SHALL complete at the latched rate.
REQ-020 An out-of-range `i_freq` SHALL leave the block in IDLE (no frame accepted).

Reset
REQ-021 `i_rst` SHALL force state IDLE, with `o_data`=8'h00, `o_valid`=0, `o_frame_err`=0, `o_busy`=0, and the shift register and bit counter cleared.
REQ-022 The synchronizer flops SHALL reset to 1 (idle line).
REQ-023 Reset mid-frame SHALL abort the frame with no output pulse; the next frame SHALL require a fresh falling edge.

Configuration
REQ-024 Macro `UART_RX_PARITY_EN` SHALL control even parity.
  - Defined: PARITY state is present; one even-parity bit follows data; output `o_parity_err` (1-bit, reset 0) pulses with `o_valid` when the XOR of data bits and parity bit is 1; `o_data` still updates.
  - Undefined: PARITY state, parity logic and `o_parity_err` port are absent; DATA goes directly to STOP.

Structure
REQ-025 The shared package SHALL contain:
  - `uart_freq`, `UART_CNT_SIZE` and `UART_*_CNT` (existing);
  - new typedef `uart_rx_state` (enum of REQ-011);
  - constant `UART_DATA_BITS`=8.
REQ-026 The block SHALL contain one sub-module: `uart_clk_div` with RESET_TO_HALF=1.
  - Reset by `i_rst` OR state==IDLE.
  - Its `o_clk` is the bit tick.

Verification
REQ-027 uart_115200, send 8'hA5 8N1 -> `o_valid` one pulse, `o_data`=8'hA5, `o_frame_err`=0, `o_busy` drops the same cycle.
REQ-028 Low glitch of 1/4 bit on an idle line -> returns to IDLE, no `o_valid` or `o_frame_err`.
REQ-029 uart_9600, 8'h3C with stop bit low then line held low for 3 frames -> one `o_frame_err` pulse, `o_data` unchanged, no restart until line high then falling.
REQ-030 Back-to-back 8'h00 then 8'hFF at uart_57600 with no idle gap -> two `o_valid` pulses, data correct.
REQ-031 `i_rst` asserted during data bit 4 -> outputs at reset values, no pulse; next byte 8'h5A is received correctly.
REQ-032 With `UART_RX_PARITY_EN`: 8'h01 with parity 0 -> `o_valid`=1, `o_parity_err`=1; with parity 1 -> `o_parity_err`=0.
